// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Brief    : Shared defaults and lrck channel encoding for the I2S frame logic.
// Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int c_DATA_W    = 16;
    localparam int c_SLOT_BCKS = 32;
    // Standard I2S: MSB sits one bck after the lrck transition.
    localparam int c_I2S_DELAY = 1;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } i2s_chan_e;

endpackage
`default_nettype wire

// File: rtl/i2s_clk_div.sv
`default_nettype none
// ============================================================================
// Module   : i2s_clk_div
// Brief    : bck divider with one-clk rise/fall strobes aligned to bck.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_clk_div
    import i2s_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [DIV_W-1:0] bck_div,
    output logic             bck,
    output logic             bck_rise_stb,
    output logic             bck_fall_stb,
    output logic             bck_fall_next
);

    logic [DIV_W-1:0] r_div_cnt;
    logic [DIV_W-1:0] r_div_max;
    logic             r_bck;
    logic             r_rise_stb;
    logic             r_fall_stb;
    logic             w_term;

    assign w_term        = (r_div_cnt == r_div_max);
    // Lets the parent update bit/lrck state on the same edge bck falls.
    assign bck_fall_next = en && w_term && r_bck;

    assign bck          = r_bck;
    assign bck_rise_stb = r_rise_stb;
    assign bck_fall_stb = r_fall_stb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt  <= '0;
            r_div_max  <= '0;
            r_bck      <= 1'b0;
            r_rise_stb <= 1'b0;
            r_fall_stb <= 1'b0;
        end else if (!en) begin
            // Idle keeps tracking bck_div so the first half-period after enable is exact.
            r_div_cnt  <= '0;
            r_div_max  <= bck_div;
            r_bck      <= 1'b0;
            r_rise_stb <= 1'b0;
            r_fall_stb <= 1'b0;
        end else begin
            r_rise_stb <= 1'b0;
            r_fall_stb <= 1'b0;
            if (w_term) begin
                r_div_cnt  <= '0;
                r_div_max  <= bck_div;
                r_bck      <= ~r_bck;
                r_rise_stb <= ~r_bck;
                r_fall_stb <= r_bck;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/i2s_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : i2s_frame_controller
// Brief    : I2S bus master: bck/lrck generation, frame capture and tx load.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_frame_controller
    import i2s_pkg::*;
#(
    parameter int DATA_W    = c_DATA_W,
    parameter int SLOT_BCKS = c_SLOT_BCKS,
    parameter int DIV_W     = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         en,
    input  logic [DIV_W-1:0]             bck_div,
    output logic                         bck,
    output logic                         lrck,
    output logic                         bck_rise_stb,
    output logic                         bck_fall_stb,
    output logic [$clog2(SLOT_BCKS)-1:0] bit_idx,
    output logic                         frame_stb,
    input  logic [DATA_W-1:0]            rx_outl,
    input  logic [DATA_W-1:0]            rx_outr,
    output logic [DATA_W-1:0]            smp_l,
    output logic [DATA_W-1:0]            smp_r,
    output logic                         smp_valid,
    input  logic                         smp_ready,
    input  logic [DATA_W-1:0]            tx_l,
    input  logic [DATA_W-1:0]            tx_r,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic [DATA_W-1:0]            ser_l,
    output logic [DATA_W-1:0]            ser_r,
    output logic                         ser_load,
    output logic                         overrun,
    output logic                         underrun,
    input  logic                         clr_err
);

    localparam int                 c_IDX_W    = $clog2(SLOT_BCKS);
    localparam logic [c_IDX_W-1:0] c_LAST_BIT = c_IDX_W'(SLOT_BCKS - 1);

    logic               w_fall_next;
    logic               w_slot_wrap;
    logic               w_frame_next;
    logic               w_tx_hs;
    logic               w_ov_set;
    logic               w_un_set;

    logic [c_IDX_W-1:0] r_bit_idx;
    logic               r_lrck;
    logic               r_frame_stb;
    logic               r_ser_load;
    logic [DATA_W-1:0]  r_smp_l;
    logic [DATA_W-1:0]  r_smp_r;
    logic               r_smp_valid;
    logic               r_pend;
    logic [DATA_W-1:0]  r_pend_l;
    logic [DATA_W-1:0]  r_pend_r;
    logic [DATA_W-1:0]  r_ser_l;
    logic [DATA_W-1:0]  r_ser_r;
    logic               r_overrun;
    logic               r_underrun;

    i2s_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (en),
        .bck_div       (bck_div),
        .bck           (bck),
        .bck_rise_stb  (bck_rise_stb),
        .bck_fall_stb  (bck_fall_stb),
        .bck_fall_next (w_fall_next)
    );

    assign w_slot_wrap  = (r_bit_idx == c_LAST_BIT);
    // The fall that ends the right slot is the frame boundary.
    assign w_frame_next = w_fall_next && w_slot_wrap && (r_lrck == RIGHT);
    assign w_tx_hs      = tx_valid && !r_pend;
    assign w_ov_set     = r_frame_stb && r_smp_valid && !smp_ready;
    assign w_un_set     = w_frame_next && !r_pend;

    assign lrck      = r_lrck;
    assign bit_idx   = r_bit_idx;
    assign frame_stb = r_frame_stb;
    assign ser_load  = r_ser_load;
    assign smp_l     = r_smp_l;
    assign smp_r     = r_smp_r;
    assign smp_valid = r_smp_valid;
    assign tx_ready  = !r_pend;
    assign ser_l     = r_ser_l;
    assign ser_r     = r_ser_r;
    assign overrun   = r_overrun;
    assign underrun  = r_underrun;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_idx   <= '0;
            r_lrck      <= LEFT;
            r_frame_stb <= 1'b0;
            r_ser_load  <= 1'b0;
        end else if (!en) begin
            r_bit_idx   <= '0;
            r_lrck      <= LEFT;
            r_frame_stb <= 1'b0;
            r_ser_load  <= 1'b0;
        end else begin
            r_frame_stb <= w_frame_next;
            r_ser_load  <= w_frame_next;
            if (w_fall_next) begin
                if (w_slot_wrap) begin
                    r_bit_idx <= '0;
                    r_lrck    <= ~r_lrck;
                end else begin
                    r_bit_idx <= r_bit_idx + 1'b1;
                end
            end
        end
    end

    // Receive capture happens at the end of the frame_stb cycle so a consumer
    // handshake in that cycle frees the buffer for the new pair.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_smp_l     <= '0;
            r_smp_r     <= '0;
            r_smp_valid <= 1'b0;
        end else if (r_frame_stb) begin
            if (!r_smp_valid || smp_ready) begin
                r_smp_l     <= rx_outl;
                r_smp_r     <= rx_outr;
                r_smp_valid <= 1'b1;
            end
        end else if (smp_ready && r_smp_valid) begin
            r_smp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend   <= 1'b0;
            r_pend_l <= '0;
            r_pend_r <= '0;
            r_ser_l  <= '0;
            r_ser_r  <= '0;
        end else begin
            if (w_frame_next) begin
                r_ser_l <= r_pend ? r_pend_l : '0;
                r_ser_r <= r_pend ? r_pend_r : '0;
            end
            if (w_frame_next && r_pend) begin
                r_pend <= 1'b0;
            end else if (w_tx_hs) begin
                r_pend   <= 1'b1;
                r_pend_l <= tx_l;
                r_pend_r <= tx_r;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_overrun  <= w_ov_set | (r_overrun & ~clr_err);
            r_underrun <= w_un_set | (r_underrun & ~clr_err);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_frame_controller
// Brief    : Directed frame table plus randomized run against a timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_frame_controller;

    localparam int DW    = 16;
    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             en;
    logic [DIV_W-1:0] bck_div;
    logic             bck, lrck, bck_rise_stb, bck_fall_stb, frame_stb;
    logic [4:0]       bit_idx;
    logic [DW-1:0]    rx_outl, rx_outr, smp_l, smp_r, tx_l, tx_r, ser_l, ser_r;
    logic             smp_valid, smp_ready, tx_valid, tx_ready, ser_load;
    logic             overrun, underrun, clr_err;

    always #5 clk = ~clk;

    i2s_frame_controller #(.DATA_W(DW), .SLOT_BCKS(32), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .bck_div(bck_div),
        .bck(bck), .lrck(lrck), .bck_rise_stb(bck_rise_stb), .bck_fall_stb(bck_fall_stb),
        .bit_idx(bit_idx), .frame_stb(frame_stb),
        .rx_outl(rx_outl), .rx_outr(rx_outr), .smp_l(smp_l), .smp_r(smp_r),
        .smp_valid(smp_valid), .smp_ready(smp_ready),
        .tx_l(tx_l), .tx_r(tx_r), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ser_l(ser_l), .ser_r(ser_r), .ser_load(ser_load),
        .overrun(overrun), .underrun(underrun), .clr_err(clr_err)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // After e enabled edges with half-period d+1 clk: toggles n = e/(d+1),
    // falls = n/2; slot bit = falls mod 32, lrck = slot parity.
    // Returns {bck, lrck, rise, fall, frame, bit_idx[4:0]}.
    function automatic logic [9:0] m_timing(input int e, input int d);
        logic [9:0] r;
        int n, f;
        logic tl;
        n    = e / (d + 1);
        f    = n / 2;
        tl   = (e > 0) && ((e % (d + 1)) == 0);
        r[9] = (n % 2) == 1;
        r[8] = ((f / 32) % 2) == 1;
        r[7] = tl && ((n % 2) == 1);
        r[6] = tl && ((n % 2) == 0);
        r[5] = tl && ((n % 2) == 0) && ((f % 64) == 0);
        r[4:0] = 5'(f % 32);
        return r;
    endfunction

    typedef struct {
        logic [15:0] rx_l;
        logic [15:0] rx_r;
        logic        rdy;
        logic        rdy_pulse;
        logic        offer;
        logic [15:0] tx_l;
        logic [15:0] tx_r;
        logic        clr_start;
        logic        clr_hold;
        logic [15:0] e_ser_l;
        logic [15:0] e_ser_r;
        logic        e_un;
        logic [15:0] e_smp_l;
        logic [15:0] e_smp_r;
        logic        e_v;
        logic        e_ov;
    } frame_vec_t;

    frame_vec_t vt[5];

    // Random-phase model state
    int          m_e, m_d, dis_left;
    logic [15:0] m_sl, m_sr, m_pl, m_pr, m_xl, m_xr;
    logic        m_v, m_p, m_ov, m_un, m_ld;

    initial begin
        int          guard;
        int          last_frame;
        logic [9:0]  tnow, tnext;
        logic        ov_set, un_set, hs;

        vt[0] = '{16'hFEFF, 16'hCACA, 1'b1, 1'b0, 1'b1, 16'h5A5A, 16'hA5A5, 1'b0, 1'b0,
                  16'h5A5A, 16'hA5A5, 1'b0, 16'hFEFF, 16'hCACA, 1'b1, 1'b0};
        vt[1] = '{16'h1111, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0,
                  16'h0000, 16'h0000, 1'b1, 16'h1111, 16'h1111, 1'b1, 1'b0};
        vt[2] = '{16'h2222, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0,
                  16'h1234, 16'h4321, 1'b0, 16'h1111, 16'h1111, 1'b1, 1'b1};
        vt[3] = '{16'h3333, 16'h3333, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0,
                  16'h0000, 16'h0000, 1'b1, 16'h3333, 16'h3333, 1'b1, 1'b0};
        vt[4] = '{16'h4444, 16'h5555, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1,
                  16'h0000, 16'h0000, 1'b1, 16'h4444, 16'h5555, 1'b1, 1'b0};

        reset_n = 1'b0; en = 1'b0; bck_div = 8'd1; smp_ready = 1'b0; clr_err = 1'b0;
        rx_outl = '0; rx_outr = '0; tx_l = '0; tx_r = '0; tx_valid = 1'b0;
        tick(); tick();
        chk("reset_ctl", {bck, lrck, bck_rise_stb, bck_fall_stb, bit_idx, frame_stb,
                          smp_valid, ser_load, overrun, underrun, tx_ready}, 64'h1);
        chk("reset_data", {smp_l, smp_r, ser_l, ser_r}, 64'h0);

        reset_n = 1'b1;
        tick(); tick();
        en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("clkgen", {bck, bck_rise_stb, bck_fall_stb},
                {((i / 2) % 2) == 1, (i % 2 == 0) && ((i / 2) % 2 == 1),
                 (i % 2 == 0) && ((i / 2) % 2 == 0)});
        end

        last_frame = 0;
        for (int i = 0; i < 5; i++) begin
            rx_outl   = vt[i].rx_l;
            rx_outr   = vt[i].rx_r;
            smp_ready = vt[i].rdy;
            clr_err   = vt[i].clr_start | vt[i].clr_hold;
            tick();
            if (!vt[i].clr_hold) clr_err = 1'b0;
            if (vt[i].offer) begin
                chk("tx_ready_idle", tx_ready, 1'b1);
                tx_l = vt[i].tx_l; tx_r = vt[i].tx_r; tx_valid = 1'b1;
                tick();
                chk("tx_ready_fall", tx_ready, 1'b0);
                tx_valid = 1'b0;
            end
            guard = 0;
            while (!frame_stb && guard < 1000) begin
                tick();
                guard++;
            end
            chk("frame_stb_seen", frame_stb, 1'b1);
            if (i > 0) chk("frame_period", 64'(cyc - last_frame), 64'd256);
            last_frame = cyc;
            chk("frame_tx", {ser_load, tx_ready, ser_l, ser_r},
                {2'b11, vt[i].e_ser_l, vt[i].e_ser_r});
            chk("frame_underrun", underrun, vt[i].e_un);
            clr_err = 1'b0;
            if (vt[i].rdy_pulse) smp_ready = 1'b1;
            tick();
            chk("capture", {smp_valid, smp_l, smp_r}, {vt[i].e_v, vt[i].e_smp_l, vt[i].e_smp_r});
            chk("overrun", overrun, vt[i].e_ov);
            if (vt[i].rdy_pulse) smp_ready = 1'b0;
        end

        // Disable at bit 10 of the right slot
        guard = 0;
        while (!(lrck && bit_idx == 5'd10) && guard < 1000) begin
            tick();
            guard++;
        end
        chk("right_bit10_seen", {lrck, bit_idx}, {1'b1, 5'd10});
        en = 1'b0;
        tick();
        chk("disable_clear", {bck, lrck, bit_idx, bck_rise_stb, bck_fall_stb, frame_stb}, 64'h0);
        chk("disable_keep", {smp_valid, smp_l}, {1'b1, 16'h4444});
        en = 1'b1;
        tick();
        chk("reenable_start", {lrck, bit_idx}, 64'h0);
        for (int i = 0; i < 50; i++) tick();

        // Asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset_ctl", {bck, lrck, bck_rise_stb, bck_fall_stb, bit_idx, frame_stb,
                                smp_valid, ser_load, overrun, underrun, tx_ready}, 64'h1);
        chk("async_reset_data", {smp_l, smp_r, ser_l, ser_r}, 64'h0);

        // Randomized run against the model
        en = 1'b0; clr_err = 1'b0; smp_ready = 1'b0; tx_valid = 1'b0;
        m_e = 0; m_d = 1; dis_left = 3;
        m_sl = '0; m_sr = '0; m_pl = '0; m_pr = '0; m_xl = '0; m_xr = '0;
        m_v = 1'b0; m_p = 1'b0; m_ov = 1'b0; m_un = 1'b0; m_ld = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 20000; c++) begin
            if (en && $urandom_range(0, 999) == 0) begin
                en = 1'b0;
                dis_left = 2 + int'($urandom_range(0, 3));
            end else if (!en) begin
                dis_left--;
                if (dis_left == 0) begin
                    en = 1'b1;
                end else if (m_e == 0) begin
                    m_d = int'($urandom_range(0, 3));
                    bck_div = 8'(m_d);
                end
            end
            smp_ready = ($urandom_range(0, 149) == 0);
            tx_valid  = ($urandom_range(0, 199) == 0);
            clr_err   = ($urandom_range(0, 399) == 0);
            rx_outl = 16'($urandom); rx_outr = 16'($urandom);
            tx_l    = 16'($urandom); tx_r    = 16'($urandom);

            tnow   = m_timing(m_e, m_d);
            tnext  = en ? m_timing(m_e + 1, m_d) : 10'd0;
            ov_set = 1'b0;
            un_set = 1'b0;
            hs     = tx_valid && !m_p;
            if (tnow[5]) begin
                if (!m_v || smp_ready) begin
                    m_sl = rx_outl; m_sr = rx_outr; m_v = 1'b1;
                end else begin
                    ov_set = 1'b1;
                end
            end else if (smp_ready && m_v) begin
                m_v = 1'b0;
            end
            if (tnext[5]) begin
                if (m_p) begin
                    m_xl = m_pl; m_xr = m_pr; m_p = 1'b0;
                end else begin
                    m_xl = '0; m_xr = '0; un_set = 1'b1;
                end
            end
            if (hs) begin
                m_p = 1'b1; m_pl = tx_l; m_pr = tx_r;
            end
            m_ov = ov_set | (m_ov & !clr_err);
            m_un = un_set | (m_un & !clr_err);
            m_ld = tnext[5];
            m_e  = en ? m_e + 1 : 0;

            tick();
            chk("timing", {bck, lrck, bck_rise_stb, bck_fall_stb, frame_stb, bit_idx},
                m_timing(m_e, m_d));
            chk("rx_buf", {smp_valid, smp_l, smp_r}, {m_v, m_sl, m_sr});
            chk("tx_buf", {ser_load, tx_ready, ser_l, ser_r}, {m_ld, !m_p, m_xl, m_xr});
            chk("err_flags", {overrun, underrun}, {m_ov, m_un});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_frame_controller.md
Name: i2s_frame_controller

Overview:
- I2S bus master and sequencer for the audio serial-to-parallel and parallel-to-serial blocks.
- Derives bck and lrck from the system clock and issues one-clock edge strobes. The deserializer and serializer sample or shift on these strobes.
- At each frame boundary it captures the deserialized left/right pair into a valid/ready output buffer. It also loads the next transmit pair from a valid/ready input buffer.
- Sits between the codec pins (audio_serial_to_parallel on the receive path) and the sample-processing fabric.

Parameters:
DATA_W, 16, sample width per channel
SLOT_BCKS, 32, bck periods per channel slot; must be >= DATA_W+1
DIV_W, 8, width of bck_div

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset_n  in  1  asynchronous active-low reset
en  in  1  run enable
bck_div  in  DIV_W  bck half-period in clk cycles, minus 1
bck  out  1  I2S bit clock
lrck  out  1  I2S word select; 0 = left, 1 = right
bck_rise_stb  out  1  one-clk pulse in the cycle bck goes 0->1
bck_fall_stb  out  1  one-clk pulse in the cycle bck goes 1->0
bit_idx  out  log2(SLOT_BCKS)  bit position in the current slot
frame_stb  out  1  one-clk pulse when lrck goes 1->0
rx_outl  in  DATA_W  left word from deserializer
rx_outr  in  DATA_W  right word from deserializer
smp_l  out  DATA_W  captured left sample
smp_r  out  DATA_W  captured right sample
smp_valid  out  1  captured pair available
smp_ready  in  1  consumer accepts pair
tx_l  in  DATA_W  transmit left sample
tx_r  in  DATA_W  transmit right sample
tx_valid  in  1  transmit pair offered
tx_ready  out  1  pending buffer empty
ser_l  out  DATA_W  active left word to serializer
ser_r  out  DATA_W  active right word to serializer
ser_load  out  1  one-clk pulse, coincident with frame_stb
overrun  out  1  sticky: receive pair dropped
underrun  out  1  sticky: no transmit pair available at frame
clr_err  in  1  clears overrun/underrun

Behaviour:
- Reset: every output register is 0, and the divider counter and bit counter are 0. Combinational consequence: tx_ready = 1.
- Divider:
  - div_cnt counts 0..bck_div; at the terminal count it returns to 0 and bck toggles.
  - bck_div is sampled only at the terminal count.
  - bck period = 2*(bck_div+1) clk.
- Strobes are registered and updated in the same cycle as the bck register toggle, so they align exactly with the bck edge.
- Bit counter: advances on each bck fall, 0..SLOT_BCKS-1. On wrap, lrck toggles on that same fall edge, and bit_idx = 0 during the first bck of each slot.
- I2S one-bit delay: the MSB is driven/sampled at bit_idx = 1 and the LSB at bit_idx = DATA_W. Bits DATA_W+1..SLOT_BCKS-1 are idle.
- frame_stb: asserted on the fall edge where lrck goes 1->0.
- Receive capture (on frame_stb):
  - If !smp_valid, or smp_ready is high in the same cycle: smp_l/smp_r <= rx_outl/rx_outr and smp_valid = 1.
  - Otherwise: keep the old pair and set overrun.
  - smp_ready && smp_valid with no frame_stb: smp_valid <= 0.
- Transmit:
  - A pending register is loaded on tx_valid && tx_ready; tx_ready = !pending.
  - On frame_stb with pending: ser_l/ser_r <= pending pair, pending cleared. A tx handshake in the same cycle is not allowed, because tx_ready = 0.
  - On frame_stb with no pending: ser_l/ser_r <= 0 and underrun is set.
  - ser_load pulses on every frame_stb.
- Error flags: clr_err clears them; a set in the same cycle wins over the clear.
- en = 0:
  - Synchronously clears div_cnt, bit counter, bck, lrck and strobes in the next cycle.
  - Sample buffers, flags and handshakes keep operating.
  - Re-enable starts at bit_idx = 0, left slot.
- Asynchronous reset mid-frame returns everything to reset values immediately.

Decomposition:
- Package i2s_pkg: default DATA_W, default SLOT_BCKS, I2S_DELAY = 1, LEFT = 0 / RIGHT = 1 lrck encodings.
- Sub-module i2s_clk_div: divider, bck register, rise/fall strobes.

Test Plan:
- Clock generation: reset then en = 1, bck_div = 1 -> bck period 4 clk; lrck period 256 clk (SLOT_BCKS = 32); frame_stb every 256 clk; strobes exactly one clk wide.
- Receive capture: drive rx_outr = 16'hCACA, rx_outl = 16'hFEFF, smp_ready = 1 -> smp_valid at first frame_stb with smp_l = FEFF, smp_r = CACA.
- Overrun: smp_ready = 0 across two frames with values 1111 then 2222 -> smp_l stays 1111, overrun = 1; clr_err -> overrun 0.
- Transmit and underrun: tx pair 5A5A/A5A5 offered -> tx_ready falls; at next frame_stb ser_l = 5A5A, ser_r = A5A5, ser_load = 1, tx_ready = 1; no new offer -> next frame ser_l = ser_r = 0, underrun = 1.
- Simultaneous events: smp_ready pulse in the frame_stb cycle with smp_valid = 1 -> new pair loaded, no overrun; clr_err in the same cycle as an underrun set -> underrun = 1.
- Disable and reset mid-frame: en = 0 at bit_idx = 10 of the right slot -> next cycle bck = 0, lrck = 0, bit_idx = 0, smp_valid unchanged; reset_n low mid-frame -> all outputs 0 without a clock edge.
